// File: rtl/rsa_operand_loader.sv
// Word-serial operand loader for the RSA-4096 exponentiation core.
// Define RSA_LOADER_KEY_REUSE_EN to let a new message reuse the previous exponent/modulus.
module rsa_operand_loader #(
    parameter int RSA_WIDTH  = 4096,
    parameter int WORD_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [RSA_WIDTH-1:0]  message,
    output logic [RSA_WIDTH-1:0]  exponent,
    output logic [RSA_WIDTH-1:0]  modulus,
    output logic                  go,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  job_done,
    output logic                  frame_err,
`ifdef RSA_LOADER_KEY_REUSE_EN
    input  logic                  reuse_key,
`endif
    output logic [15:0]           job_count
);

    localparam int NWORDS = RSA_WIDTH / WORD_WIDTH;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        LOAD_M,
        LOAD_E,
        LOAD_N,
        FIRE,
        WAIT_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] word_idx;
    logic          done_q;
    logic          loading;
    logic          xfer;
    logic          at_end;
    logic          bad_frame;
    logic          reuse_hit;

    assign loading   = (state == LOAD_M) || (state == LOAD_E) || (state == LOAD_N);
    assign s_ready   = loading && !reset;
    assign xfer      = s_valid && s_ready;
    assign at_end    = (word_idx == IW'(NWORDS - 1));
    assign bad_frame = s_last ^ at_end;

`ifdef RSA_LOADER_KEY_REUSE_EN
    logic key_valid;
    assign reuse_hit = reuse_key && key_valid;
`else
    assign reuse_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD_M;
            word_idx  <= '0;
            message   <= '0;
            exponent  <= '0;
            modulus   <= '0;
            go        <= 1'b0;
            busy      <= 1'b0;
            job_done  <= 1'b0;
            frame_err <= 1'b0;
            job_count <= '0;
            done_q    <= 1'b0;
`ifdef RSA_LOADER_KEY_REUSE_EN
            key_valid <= 1'b0;
`endif
        end else begin
            go        <= 1'b0;
            job_done  <= 1'b0;
            frame_err <= 1'b0;
            // Track the done level every cycle so a level held over from the
            // previous job is already "seen" when WAIT_DONE is entered.
            done_q    <= core_done;
            unique case (state)
                LOAD_M, LOAD_E, LOAD_N: begin
                    if (xfer) begin
                        if (bad_frame) begin
                            frame_err <= 1'b1;
                            word_idx  <= '0;
                            state     <= LOAD_M;
`ifdef RSA_LOADER_KEY_REUSE_EN
                            key_valid <= 1'b0;
`endif
                        end else begin
                            word_idx <= at_end ? '0 : word_idx + 1'b1;
                            unique case (state)
                                LOAD_M: begin
                                    message[word_idx*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                                    if (at_end) begin
                                        if (reuse_hit) begin
                                            go    <= 1'b1;
                                            state <= FIRE;
                                        end else begin
                                            state <= LOAD_E;
                                        end
                                    end
                                end
                                LOAD_E: begin
                                    exponent[word_idx*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                                    if (at_end) state <= LOAD_N;
                                end
                                default: begin
                                    modulus[word_idx*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                                    if (at_end) begin
                                        go    <= 1'b1;
                                        state <= FIRE;
`ifdef RSA_LOADER_KEY_REUSE_EN
                                        key_valid <= 1'b1;
`endif
                                    end
                                end
                            endcase
                        end
                    end
                end
                FIRE: begin
                    busy  <= 1'b1;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (core_done && !done_q) begin
                        job_done  <= 1'b1;
                        busy      <= 1'b0;
                        job_count <= job_count + 16'd1;
                        state     <= LOAD_M;
                    end
                end
                default: state <= LOAD_M;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomized bench for rsa_operand_loader with a word-array reference model.
`timescale 1ns/1ps
module tb_rsa_operand_loader;

    localparam int RW = 4096;
    localparam int WW = 64;
    localparam int NW = RW / WW;
`ifdef RSA_LOADER_KEY_REUSE_EN
    localparam bit REUSE_EN = 1'b1;
`else
    localparam bit REUSE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          core_done = 1'b0;
    logic          reuse_key = 1'b0;
    logic          s_ready, go, busy, job_done, frame_err;
    logic [15:0]   job_count;
    logic [RW-1:0] message, exponent, modulus;

    int checks = 0;
    int errors = 0;
    int jd_seen = 0;

    always #5 clk = ~clk;

    rsa_operand_loader dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .message   (message),
        .exponent  (exponent),
        .modulus   (modulus),
        .go        (go),
        .core_done (core_done),
        .busy      (busy),
        .job_done  (job_done),
        .frame_err (frame_err),
`ifdef RSA_LOADER_KEY_REUSE_EN
        .reuse_key (reuse_key),
`endif
        .job_count (job_count)
    );

    // Reference model: per-operand word arrays and a running word position in the frame.
    logic [WW-1:0] mo[3][NW];
    int  pos = 0;
    int  m_cnt = 0;
    bit  m_fire, m_run, m_busy, m_jd, m_fe, m_kv, m_pd, started;

    always @(posedge clk) begin
        bit rdy;
        int op, w;
        rdy = !reset && !m_fire && !m_run;
        if (reset) begin
            for (int o = 0; o < 3; o++)
                for (int i = 0; i < NW; i++) mo[o][i] = '0;
            pos = 0; m_cnt = 0;
            m_fire = 0; m_run = 0; m_busy = 0; m_jd = 0; m_fe = 0; m_kv = 0;
            started = 1;
        end else begin
            m_jd = 0; m_fe = 0;
            if (m_fire) begin
                m_fire = 0; m_run = 1; m_busy = 1;
            end else if (m_run) begin
                if (core_done && !m_pd) begin
                    m_jd = 1; m_busy = 0; m_run = 0;
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end else if (s_valid && rdy) begin
                op = pos / NW;
                w  = pos % NW;
                if (s_last != (w == NW - 1)) begin
                    m_fe = 1; pos = 0; m_kv = 0;
                end else begin
                    mo[op][w] = s_data;
                    if (REUSE_EN && op == 0 && w == NW - 1 && reuse_key && m_kv) begin
                        m_fire = 1; pos = 0;
                    end else if (pos == 3 * NW - 1) begin
                        m_fire = 1; m_kv = 1; pos = 0;
                    end else begin
                        pos++;
                    end
                end
            end
        end
        m_pd = reset ? 1'b0 : core_done;
    end

    task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < NW; i++)
                if (act[i*WW +: WW] !== exp[i*WW +: WW]) begin
                    $display("FAIL %s: word %0d got %h expected %h at %0t",
                             name, i, act[i*WW +: WW], exp[i*WW +: WW], $time);
                    break;
                end
        end
    endtask

    always @(negedge clk) begin
        logic [RW-1:0] em, ee, en;
        if (started) begin
            for (int i = 0; i < NW; i++) begin
                em[i*WW +: WW] = mo[0][i];
                ee[i*WW +: WW] = mo[1][i];
                en[i*WW +: WW] = mo[2][i];
            end
            chk1("s_ready", 32'(s_ready), 32'(!reset && !m_fire && !m_run));
            chk1("go", 32'(go), 32'(m_fire));
            chk1("busy", 32'(busy), 32'(m_busy));
            chk1("job_done", 32'(job_done), 32'(m_jd));
            chk1("frame_err", 32'(frame_err), 32'(m_fe));
            chk1("job_count", 32'(job_count), 32'(m_cnt));
            chk1("go_vs_ferr", 32'(go && frame_err), 32'd0);
            chkw("message", message, em);
            chkw("exponent", exponent, ee);
            chkw("modulus", modulus, en);
            if (job_done === 1'b1) jd_seen++;
        end
    end

    // Stimulus operands
    logic [WW-1:0] sm[3][NW];

    task automatic new_ops();
        for (int i = 0; i < NW; i++) begin
            sm[0][i] = {$urandom, $urandom};
            sm[1][i] = '0;
            sm[2][i] = {$urandom, $urandom};
        end
        sm[0][0][7:0] = 8'h05;
        sm[1][0] = 64'd65537;
        sm[2][0][0] = 1'b1;
        sm[2][NW-1][WW-1] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [WW-1:0] d, input bit last, input bit gaps);
        int  n;
        bit  r;
        if (gaps)
            while ($urandom_range(1, 0) == 1) begin
                s_valid = 1'b0;
                tick();
            end
        s_valid = 1'b1; s_data = d; s_last = last; n = 0;
        forever begin
            r = s_ready;
            tick();
            if (r) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: word not accepted after %0d cycles", n);
                break;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_op(input int op, input bit gaps);
        for (int i = 0; i < NW; i++) send(sm[op][i], i == NW - 1, gaps);
    endtask

    task automatic stream_all(input bit gaps);
        for (int o = 0; o < 3; o++) send_op(o, gaps);
    endtask

    task automatic wait_jd();
        int n = 0;
        while (job_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk1("job_done_seen", 32'(job_done), 32'd1);
    endtask

    task automatic finish_job();
        repeat (3) tick();
        core_done = 1'b1;
        wait_jd();
        tick();
        core_done = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        reset = 1'b1;
        repeat (2) tick();
        chk1("rst_s_ready", 32'(s_ready), 32'd0);
        chkw("rst_message", message, '0);
        chk1("rst_job_count", 32'(job_count), 32'd0);
        reset = 1'b0;
        tick();

        // Job 1: full stream, fixed exponent 65537
        new_ops();
        stream_all(1'b0);
        chk1("go_latency", 32'(go), 32'd1);
        chk1("msg_lsb", 32'(message[7:0]), 32'h05);
        chk1("exp_lo", exponent[31:0], 32'd65537);
        chk1("exp_hi", exponent[63:32], 32'd0);
        tick();
        chk1("go_one_cycle", 32'(go), 32'd0);
        chk1("busy_after_go", 32'(busy), 32'd1);
        repeat (3) tick();
        core_done = 1'b1;
        wait_jd();
        chk1("job_count_1", 32'(job_count), 32'd1);
        tick();

        // Job 2: done level stays high through load and FIRE
        new_ops();
        stream_all(1'b0);
        repeat (10) tick();
        chk1("no_false_done", 32'(busy), 32'd1);
        chk1("jd_seen_1", jd_seen, 32'd1);
        core_done = 1'b0;
        repeat (40) tick();
        core_done = 1'b1;
        wait_jd();
        chk1("s_ready_after_done", 32'(s_ready), 32'd1);
        chk1("job_count_2", 32'(job_count), 32'd2);
        tick();
        core_done = 1'b0;
        chk1("jd_seen_2", jd_seen, 32'd2);

        // Framing error at message word 10
        new_ops();
        for (int i = 0; i < 10; i++) send(sm[0][i], 1'b0, 1'b0);
        send(sm[0][10], 1'b1, 1'b0);
        chk1("frame_err_pulse", 32'(frame_err), 32'd1);
        chk1("no_go_on_ferr", 32'(go), 32'd0);
        tick();
        stream_all(1'b0);
        chk1("go_after_ferr", 32'(go), 32'd1);
        finish_job();

        // Random valid gaps
        new_ops();
        stream_all(1'b1);
        chk1("go_latency_gaps", 32'(go), 32'd1);
        finish_job();

        // Reset mid-exponent
        base = int'(job_count);
        chk1("count_before_rst", base, 32'd4);
        new_ops();
        send_op(0, 1'b0);
        for (int i = 0; i < 30; i++) send(sm[1][i], 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chkw("rst_mid_msg", message, '0);
        chkw("rst_mid_exp", exponent, '0);
        chk1("rst_mid_ready", 32'(s_ready), 32'd0);
        chk1("rst_mid_count", 32'(job_count), 32'd0);
        reset = 1'b0;
        tick();

        // Reset while waiting on the core
        new_ops();
        stream_all(1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk1("rst_wait_busy", 32'(busy), 32'd0);
        chk1("rst_wait_go", 32'(go), 32'd0);
        chkw("rst_wait_mod", modulus, '0);
        reset = 1'b0;
        tick();

`ifdef RSA_LOADER_KEY_REUSE_EN
        new_ops();
        stream_all(1'b0);
        finish_job();
        for (int i = 0; i < NW; i++) sm[0][i] = {$urandom, $urandom};
        reuse_key = 1'b1;
        send_op(0, 1'b0);
        reuse_key = 1'b0;
        chk1("reuse_go", 32'(go), 32'd1);
        for (int i = 0; i < NW; i++) chk1("reuse_exp_kept", exponent[i*WW +: 32], sm[1][i][31:0]);
        finish_job();
        send(sm[0][0], 1'b1, 1'b0);
        chk1("reuse_ferr", 32'(frame_err), 32'd1);
        tick();
        reuse_key = 1'b1;
        send_op(0, 1'b0);
        reuse_key = 1'b0;
        chk1("reuse_blocked", 32'(go), 32'd0);
        send_op(1, 1'b0);
        send_op(2, 1'b0);
        chk1("reuse_full_go", 32'(go), 32'd1);
        finish_job();
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
